score_time_keeper: RTL
======================

Name: score_time_keeper

Overview:
Game-state stage directly upstream of the score/time display block. Holds the live score and the countdown timer (seconds), and detects game over. Drives the display's score_to_display / time_remained inputs from snapshot registers that stay stable while a draw is in progress. Issues enable_score_and_time_display requests and consumes display_score_and_time_done, so the display is redrawn only when a value has changed.

Parameters:
TICK_DIV, 50000000, clk cycles per game second (>=2)
GAME_SECONDS, 60, countdown start value (1..4095)
DONE_TIMEOUT, 65535, max cycles to wait for display done before abandoning the request

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
start_game  in  1  one-cycle pulse; (re)starts a game
pause  in  1  level; freezes the prescaler and countdown while high
add_score_valid  in  1  one-cycle strobe; add add_score_value to score
add_score_value  in  12  points to add (unsigned)
display_score_and_time_done  in  1  pulse from display: draw finished
score_to_display  out  12  snapshot of score, to display
time_remained  out  12  snapshot of seconds remaining, to display
enable_score_and_time_display  out  1  one-cycle draw request
game_active  out  1  high while in RUN
time_up  out  1  one-cycle pulse when countdown reaches 0

Behaviour:
- Reset (async, active-high): score=0, time=0, prescaler=0, dirty=0, game FSM=IDLE, display FSM=D_IDLE, all outputs 0.
- Game FSM states: IDLE, RUN, OVER.
  - start_game in any state (highest priority): score=0, time=GAME_SECONDS, prescaler=0, dirty=1; next state RUN.
  - RUN, pause=0: prescaler increments each cycle. At TICK_DIV-1 it wraps to 0 and time decrements by 1.
  - RUN, pause=1: prescaler and time hold. Score additions are still accepted.
  - When a tick takes time from 1 to 0: time_up=1 for that next cycle, state→OVER, dirty=1.
  - OVER: score and time frozen; add_score_valid ignored. Only start_game leaves.
  - IDLE: add_score_valid ignored.
- Score: on add_score_valid in RUN, score = min(score + add_score_value, 4095), computed 13-bit and saturated. dirty=1 even if saturated.
- Simultaneous tick and add in the same cycle: both are applied; one dirty set.
- game_active = (state==RUN), registered.
- Display FSM states: D_IDLE, D_REQ, D_WAIT.
  - D_IDLE with dirty=1: latch score→score_to_display and time→time_remained, clear dirty, go to D_REQ.
  - D_REQ: enable_score_and_time_display=1 for exactly one cycle, then D_WAIT.
  - D_WAIT: on display_score_and_time_done, go to D_IDLE. If the wait counter reaches DONE_TIMEOUT, go to D_IDLE anyway (request abandoned).
  - Snapshot outputs change only on the D_IDLE latch. They never change between an enable pulse and its done/timeout.
  - A change during D_REQ/D_WAIT sets dirty. Exactly one further request follows after done; multiple changes coalesce.
  - A done pulse received outside D_WAIT is ignored.
  - start_game does not reset the display FSM. An in-flight draw completes; the restart values follow via dirty.
- Latency: value change at cycle N → dirty at N+1 → snapshot at N+1 if D_IDLE → enable high at N+2.
- Time never underflows below 0. Score never wraps.

Test Plan:
- TICK_DIV=4, GAME_SECONDS=3; reset then start_game → enable pulse with time_remained=3, score_to_display=0; acknowledge with done. Time reaches 2,1,0 at 4-cycle intervals, each followed by a request. time_up pulses once when time hits 0; game_active drops; state OVER.
- add_score_valid with value 100, then 4000 → score_to_display 100 then 4095 (saturated). A further add of 5 still issues a request, with 4095.
- Hold done low while three score adds occur during D_WAIT → snapshot unchanged until done. Then exactly one further enable, showing the final accumulated score.
- pause=1 for 20 cycles in RUN → time unchanged and no tick requests. Release → countdown resumes with prescaler continuing from its held value.
- DONE_TIMEOUT=8, done never asserted → FSM returns to D_IDLE after 8 wait cycles. The next change produces a new enable.
- Assert reset mid-draw (in D_WAIT) → all outputs 0 immediately, asynchronously. After release, no enable until start_game.

Source files
------------

// File: rtl/score_time_keeper.sv
// ---------------------------------------------------------------------------
// score_time_keeper
//
// Game-state stage that sits directly in front of the score/time display.
// It holds the live score and the countdown timer (in game seconds) and
// detects game over. It feeds the display from snapshot registers that
// only change when a new draw is requested, so values stay stable while a
// draw is in progress. The display is redrawn only when something changed.
//
// Handshake with the display: enable_score_and_time_display is a one-cycle
// request. The snapshot outputs are valid from that cycle. They are held
// until display_score_and_time_done is seen, or until the wait gives up
// after DONE_TIMEOUT cycles. A done pulse that arrives while no request
// is outstanding is ignored.
//
// Ports:
//   clk                           system clock
//   reset                         asynchronous, active-high reset
//   start_game                    one-cycle pulse; (re)starts a game
//   pause                         level; freezes prescaler and countdown
//   add_score_valid               one-cycle strobe for add_score_value
//   add_score_value[11:0]         points to add (unsigned, saturating)
//   display_score_and_time_done   pulse from display: draw finished
//   score_to_display[11:0]        score snapshot
//   time_remained[11:0]           seconds-remaining snapshot
//   enable_score_and_time_display one-cycle draw request
//   game_active                   high while the game FSM is in RUN
//   time_up                       one-cycle pulse when the countdown hits 0
//   game_state_dbg[1:0]           game FSM state (0 IDLE, 1 RUN, 2 OVER)
//   disp_state_dbg[1:0]           display FSM state (0 D_IDLE, 1 D_REQ, 2 D_WAIT)
// ---------------------------------------------------------------------------
module score_time_keeper #(
   parameter int TICK_DIV     = 50000000,
   parameter int GAME_SECONDS = 60,
   parameter int DONE_TIMEOUT = 65535
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start_game,
   input  logic        pause,
   input  logic        add_score_valid,
   input  logic [11:0] add_score_value,
   input  logic        display_score_and_time_done,
   output logic [11:0] score_to_display,
   output logic [11:0] time_remained,
   output logic        enable_score_and_time_display,
   output logic        game_active,
   output logic        time_up,
   output logic [1:0]  game_state_dbg,
   output logic [1:0]  disp_state_dbg
);

   localparam int PW = $clog2(TICK_DIV);
   localparam int WW = $clog2(DONE_TIMEOUT + 1);
   localparam logic [PW-1:0] TICK_LAST = PW'(TICK_DIV - 1);
   localparam logic [WW-1:0] WAIT_LAST = WW'(DONE_TIMEOUT - 1);
   localparam logic [11:0]   START_TIME = 12'(GAME_SECONDS);

   typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, OVER = 2'd2} game_state_t;
   typedef enum logic [1:0] {D_IDLE = 2'd0, D_REQ = 2'd1, D_WAIT = 2'd2} disp_state_t;

   game_state_t   r_state, w_next_state;
   disp_state_t   r_dstate, w_next_dstate;

   logic [11:0]   r_score;
   logic [11:0]   r_time;
   logic [PW-1:0] r_presc;
   logic          r_time_up;
   logic          r_game_active;
   logic          r_dirty;
   logic [11:0]   r_snap_score;
   logic [11:0]   r_snap_time;
   logic [WW-1:0] r_wait_cnt;

   logic          w_run_cnt;
   logic          w_tick;
   logic          w_expire;
   logic          w_add;
   logic          w_change;
   logic          w_latch;
   logic [12:0]   w_sum;
   logic [11:0]   w_score_sat;

   // ------------------------------------------------------------------
   // Game FSM: next state and datapath strobes
   // ------------------------------------------------------------------
   always_comb begin
      w_run_cnt    = 1'b0;
      w_tick       = 1'b0;
      w_expire     = 1'b0;
      w_add        = 1'b0;
      w_next_state = r_state;

      if (r_state == RUN) begin
         w_run_cnt = !pause;
         w_tick    = !pause && (r_presc == TICK_LAST);
         w_expire  = w_tick && (r_time == 12'd1);
         w_add     = add_score_valid;
      end

      if (start_game) begin
         w_next_state = RUN;
      end else if (w_expire) begin
         w_next_state = OVER;
      end
   end

   // 13-bit sum so the carry tells us when to clamp at 4095
   assign w_sum       = {1'b0, r_score} + {1'b0, add_score_value};
   assign w_score_sat = w_sum[12] ? 12'hFFF : w_sum[11:0];

   // Any value the display shows may have changed; a tick always changes time
   assign w_change = start_game || w_tick || w_add;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_score       <= '0;
         r_time        <= '0;
         r_presc       <= '0;
         r_time_up     <= 1'b0;
         r_game_active <= 1'b0;
      end else begin
         r_game_active <= (w_next_state == RUN);
         if (start_game) begin
            r_score   <= '0;
            r_time    <= START_TIME;
            r_presc   <= '0;
            r_time_up <= 1'b0;
         end else begin
            r_time_up <= w_expire;
            if (w_run_cnt) begin
               r_presc <= (r_presc == TICK_LAST) ? '0 : r_presc + 1'b1;
            end
            if (w_tick && (r_time != 12'd0)) begin
               r_time <= r_time - 1'b1;
            end
            if (w_add) begin
               r_score <= w_score_sat;
            end
         end
      end
   end

   // ------------------------------------------------------------------
   // Display FSM
   // ------------------------------------------------------------------
   assign w_latch = (r_dstate == D_IDLE) && r_dirty;

   always_comb begin
      w_next_dstate = r_dstate;
      case (r_dstate)
         D_IDLE: begin
            if (r_dirty) w_next_dstate = D_REQ;
         end
         D_REQ: begin
            w_next_dstate = D_WAIT;
         end
         D_WAIT: begin
            if (display_score_and_time_done || (r_wait_cnt == WAIT_LAST)) begin
               w_next_dstate = D_IDLE;
            end
         end
         default: begin
            w_next_dstate = D_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_dstate <= D_IDLE;
      end else begin
         r_dstate <= w_next_dstate;
      end
   end

   // A change in the same cycle as the latch wins over the clear: the
   // snapshot captured the old value, so another draw is still owed.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_dirty <= 1'b0;
      end else if (w_change) begin
         r_dirty <= 1'b1;
      end else if (w_latch) begin
         r_dirty <= 1'b0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_snap_score <= '0;
         r_snap_time  <= '0;
         r_wait_cnt   <= '0;
      end else begin
         if (w_latch) begin
            r_snap_score <= r_score;
            r_snap_time  <= r_time;
         end
         // Counts cycles spent in D_WAIT; restarts on every new wait
         if (r_dstate == D_WAIT) begin
            r_wait_cnt <= r_wait_cnt + 1'b1;
         end else begin
            r_wait_cnt <= '0;
         end
      end
   end

   // ------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------
   assign score_to_display              = r_snap_score;
   assign time_remained                 = r_snap_time;
   assign enable_score_and_time_display = (r_dstate == D_REQ);
   assign game_active                   = r_game_active;
   assign time_up                       = r_time_up;
   assign game_state_dbg                = r_state;
   assign disp_state_dbg                = r_dstate;

endmodule
